ila_cdc_tx: RTL and testbench

- Source-side (launching) end of a 4-phase req/ack multi-bit clock-domain crossing used by the ILA.
- Accepts W-bit words in the clk_i domain through a valid/ready handshake.
- Presents each word on a held-stable data_o with a level req_o to a destination domain, and waits for that domain's ack_i.
- ack_i is asynchronous to clk_i and is synchronized internally; one accepted word is buffered during a transfer.

---
 rtl/ila_cdc_tx.sv | 130 +++++++++++++
 tb/tb_ila_cdc_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ila_cdc_tx.sv
// Launching side of a 4-phase req/ack crossing: accepts words on valid/ready,
// holds each on data_o under req_o, and buffers one extra word during a transfer.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | no transfer; req_o=0, ready for a new word
// S_REQ     | req_o=1, data_o held, waiting for synchronized ack to rise
// S_RELEASE | req_o=0, data_o held, waiting for synchronized ack to fall
module ila_cdc_tx #(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk_i,
  input  logic         arst_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  output logic         req_o,
  output logic [W-1:0] data_o,
  input  logic         ack_i,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   req_q, req_d;
  logic [W-1:0]           data_q, data_d;
  logic [W-1:0]           pend_q, pend_d;
  logic                   pend_v_q, pend_v_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ack_s;
  logic                   accept;

  assign ack_s   = sync_q[SYNC_STAGES-1];
  assign ready_o = (state_q == S_IDLE) | ~pend_v_q;
  assign accept  = valid_i & ready_o;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], ack_i};
    state_d  = state_q;
    req_d    = req_q;
    data_d   = data_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          data_d  = data_i;
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (accept) begin
          pend_d   = data_i;
          pend_v_d = 1'b1;
        end
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!ack_s) begin
          done_d = 1'b1;
          // A buffered word has priority; ready_o is low then, so no accept can collide.
          if (pend_v_q) begin
            data_d   = pend_q;
            pend_v_d = 1'b0;
            req_d    = 1'b1;
            state_d  = S_REQ;
          end else if (accept) begin
            data_d  = data_i;
            req_d   = 1'b1;
            state_d = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end else if (accept) begin
          pend_d   = data_i;
          pend_v_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      data_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      sync_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      data_q   <= data_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      sync_q   <= sync_d;
    end
  end

  assign req_o  = req_q;
  assign data_o = data_q;
  assign done_o = done_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_ila_cdc_tx.sv
// Directed bench for ila_cdc_tx: handshake timing, buffering, reset and a randomized
// stream checked against a scoreboard.
module tb_ila_cdc_tx;

  logic       clk_i = 1'b0;
  logic       arst_i;
  logic       valid_i;
  logic [7:0] data_i;
  logic       ready_o;
  logic       req_o;
  logic [7:0] data_o;
  logic       ack_i;
  logic       busy_o;
  logic       done_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int done_base;
  int rx_cnt = 0;
  bit chk_en = 1'b0;
  bit abort  = 1'b0;
  logic [7:0] sb[$];

  logic [1:0] sync_m;
  logic       prev_req;
  logic [7:0] prev_data;
  logic       prev_acks;

  ila_cdc_tx #(.W(8), .SYNC_STAGES(2)) dut (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .req_o   (req_o),
    .data_o  (data_o),
    .ack_i   (ack_i),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic step2();
    @(posedge clk_i);
    #2;
  endtask

  // Directed destination: sees req, checks the word, acks, releases once req drops.
  task automatic dest_ack(input logic [7:0] exp, input int dly);
    for (int i = 0; i < 50 && req_o !== 1'b1; i++) step();
    check("dest_req_seen", {31'd0, req_o}, 1);
    check("dest_data", {24'd0, data_o}, {24'd0, exp});
    repeat (dly) step();
    ack_i = 1'b1;
    for (int i = 0; i < 50 && req_o !== 1'b0; i++) step();
    check("dest_req_drop", {31'd0, req_o}, 0);
    ack_i = 1'b0;
  endtask

  // Reference synchronizer for the ack path, used only by the invariant checker.
  always @(posedge clk_i or posedge arst_i) begin
    if (arst_i) sync_m <= 2'b00;
    else        sync_m <= {sync_m[0], ack_i};
  end

  always @(negedge clk_i) begin
    if (done_o) done_cnt++;
    if (chk_en) begin
      if (data_o !== prev_data)
        check("inv_data_only_at_launch", {30'd0, prev_req, req_o}, 32'd1);
      if (!prev_req && req_o)
        check("inv_req_rise_ack_low", {31'd0, prev_acks}, 0);
    end
    prev_req  = req_o;
    prev_data = data_o;
    prev_acks = sync_m[1];
  end

  initial begin
    arst_i  = 1'b1;
    valid_i = 1'b0;
    data_i  = 8'h00;
    ack_i   = 1'b0;
    #3;
    check("rst_req", {31'd0, req_o}, 0);
    check("rst_data", {24'd0, data_o}, 0);
    check("rst_ready", {31'd0, ready_o}, 1);
    check("rst_busy", {31'd0, busy_o}, 0);
    check("rst_done", {31'd0, done_o}, 0);
    step(); step();
    arst_i = 1'b0;
    step();

    // single word 0xA5 with hand-timed ack
    valid_i = 1'b1; data_i = 8'hA5;
    step();
    check("t1_req", {31'd0, req_o}, 1);
    check("t1_data", {24'd0, data_o}, 32'hA5);
    check("t1_busy", {31'd0, busy_o}, 1);
    valid_i = 1'b0; data_i = 8'h00;
    step(); step(); step();
    ack_i = 1'b1;
    step();
    check("t2_req_e1", {31'd0, req_o}, 1);
    step();
    check("t2_req_e2", {31'd0, req_o}, 1);
    step();
    check("t2_req_fall", {31'd0, req_o}, 0);
    check("t2_busy_release", {31'd0, busy_o}, 1);
    ack_i = 1'b0;
    step(); step();
    check("t2_done_early", {31'd0, done_o}, 0);
    step();
    check("t2_done", {31'd0, done_o}, 1);
    check("t2_idle", {31'd0, busy_o}, 0);
    check("t2_data_held", {24'd0, data_o}, 32'hA5);
    step();
    check("t2_done_once", {31'd0, done_o}, 0);

    // back-to-back 0x11, 0x22 buffered, 0x33 held while buffer is full
    done_base = done_cnt;
    valid_i = 1'b1; data_i = 8'h11;
    step();
    check("t3_launch11", {24'd0, data_o}, 32'h11);
    data_i = 8'h22;
    step();
    check("t3_ready_low", {31'd0, ready_o}, 0);
    data_i = 8'h33;
    dest_ack(8'h11, 0);
    step(); step();
    check("t3_data_hold_release", {24'd0, data_o}, 32'h11);
    step();
    check("t3_launch22_req", {31'd0, req_o}, 1);
    check("t3_launch22_data", {24'd0, data_o}, 32'h22);
    check("t3_exit_done", {31'd0, done_o}, 1);
    check("t3_no_idle", {31'd0, busy_o}, 1);
    check("t4_ready_back", {31'd0, ready_o}, 1);
    step();
    check("t4_33_buffered", {31'd0, ready_o}, 0);
    check("t4_data_still22", {24'd0, data_o}, 32'h22);
    valid_i = 1'b0;
    dest_ack(8'h22, 2);
    step(); step(); step();
    check("t4_launch33", {24'd0, data_o}, 32'h33);
    dest_ack(8'h33, 1);
    step(); step(); step();
    check("t4_final_idle", {31'd0, busy_o}, 0);
    step();
    check("t4_done_count", done_cnt - done_base, 3);

    // reset in REQ with a pending word
    valid_i = 1'b1; data_i = 8'h44;
    step();
    data_i = 8'h55;
    step();
    valid_i = 1'b0;
    check("t5_pend_full", {31'd0, ready_o}, 0);
    #2;
    arst_i = 1'b1;
    #1;
    check("t5_rst_req", {31'd0, req_o}, 0);
    check("t5_rst_data", {24'd0, data_o}, 0);
    check("t5_rst_ready", {31'd0, ready_o}, 1);
    check("t5_rst_busy", {31'd0, busy_o}, 0);
    step();
    arst_i = 1'b0;
    repeat (10) step();
    check("t5_no_stale_req", {31'd0, req_o}, 0);
    check("t5_no_stale_busy", {31'd0, busy_o}, 0);
    check("t5_no_stale_data", {24'd0, data_o}, 0);

    // randomized stream with scoreboard
    chk_en = 1'b1;
    fork
      begin : src
        for (int n = 0; n < 500 && !abort; n++) begin
          repeat ($urandom_range(0, 3)) step();
          valid_i = 1'b1;
          data_i  = 8'($urandom);
          for (int i = 0; i < 200 && ready_o !== 1'b1; i++) step();
          if (ready_o !== 1'b1) begin
            check("t6_src_ready_timeout", {31'd0, ready_o}, 1);
            abort = 1'b1;
          end else begin
            step();
            sb.push_back(data_i);
          end
          valid_i = 1'b0;
        end
      end
      begin : dst
        for (int n = 0; n < 500 && !abort; n++) begin
          logic [31:0] exp;
          for (int i = 0; i < 300 && req_o !== 1'b1 && !abort; i++) step2();
          if (req_o !== 1'b1) begin
            check("t6_dst_req_timeout", {31'd0, req_o}, 1);
            abort = 1'b1;
          end else begin
            exp = (sb.size() > 0) ? {24'd0, sb.pop_front()} : 32'hxxxxxxxx;
            check("t6_sb_data", {24'd0, data_o}, exp);
            rx_cnt++;
            repeat ($urandom_range(0, 20)) step2();
            ack_i = 1'b1;
            for (int i = 0; i < 50 && req_o !== 1'b0; i++) step2();
            if (req_o !== 1'b0) begin
              check("t6_dst_drop_timeout", {31'd0, req_o}, 0);
              abort = 1'b1;
            end
            ack_i = 1'b0;
          end
        end
      end
    join
    repeat (6) step();
    chk_en = 1'b0;
    check("t6_rx_count", rx_cnt, 500);
    check("t6_sb_empty", sb.size(), 0);
    check("t6_end_idle", {31'd0, busy_o}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
